mult_result_accum: RTL and testbench
====================================

MULT_RESULT_ACCUM -- requirements
Module: mult_result_accum

Interface
REQ-001 Parameter ACC_W, default 80: accumulator and acc_sum width in bits, at least 65.
REQ-002 Parameter CNT_W, default 8: width of term_count and acc_terms.
REQ-003 clk_32b  input  1  sole clock; all state changes on its rising edge.
REQ-004 resetn_32b  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse that begins a new accumulation.
REQ-006 term_count  input  CNT_W  number of products to accumulate; sampled when start is accepted.
REQ-007 in_valid  input  1  result_64b carries a valid product this cycle.
REQ-008 result_64b  input  64  unsigned product from the 32b x 32b multiplier.
REQ-009 in_ready  output  1  block accepts result_64b this cycle.
REQ-010 acc_valid  output  1  acc_sum, acc_terms and overflow are final and held.
REQ-011 acc_ready  input  1  downstream consumes the final result.
REQ-012 acc_sum  output  ACC_W  running, then final, unsigned sum.
REQ-013 acc_terms  output  CNT_W  number of products accepted so far.
REQ-014 overflow  output  1  sticky; set by any carry out of ACC_W bits during this accumulation.

Function
REQ-015 The block SHALL have three states: IDLE, ACCUM and HOLD.
REQ-016 IDLE: in_ready=0 and acc_valid=0; acc_sum, acc_terms and overflow keep their last values.
REQ-017 IDLE, start=1, term_count>0: clear acc_sum, acc_terms and overflow, latch term_count, go to ACCUM next cycle.
REQ-018 IDLE, start=1, term_count=0: clear acc_sum, acc_terms and overflow, go directly to HOLD.
REQ-019 ACCUM: in_ready=1; a product is accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-020 Each accepted product SHALL be zero-extended to ACC_W and added to acc_sum; acc_terms increments by 1; both are visible the cycle after acceptance.
REQ-021 When the accepted product is number latched-count, the next state SHALL be HOLD and acc_valid SHALL be 1 on the cycle after acceptance; the block SHALL NOT accept a further product.
REQ-022 ACCUM, start=1: abort the current accumulation; clear acc_sum, acc_terms and overflow, relatch term_count; any in_valid that cycle SHALL be discarded; stay in ACCUM, or go to HOLD if term_count=0.
REQ-023 HOLD: acc_valid=1, in_ready=0; outputs SHALL stay stable until acc_ready=1; start is ignored.
REQ-024 HOLD, acc_ready=1: go to IDLE next cycle; acc_valid falls that cycle; start is accepted in the following IDLE cycle at the earliest.
REQ-025 in_valid without in_ready SHALL have no effect; there is no input buffering.
REQ-026 overflow SHALL be set whenever the ACC_W-bit addition carries out, and SHALL stay set until the next start or reset.

Reset
REQ-027 resetn_32b=0 SHALL immediately force IDLE with acc_sum=0, acc_terms=0, overflow=0, in_ready=0 and acc_valid=0, regardless of clock.
REQ-028 Reset asserted mid-ACCUM or mid-HOLD SHALL discard the accumulation; after release the block waits for start.

Configuration
REQ-029 Macro ACC_SATURATE_EN defined: on carry-out, acc_sum SHALL clamp to all-ones and stay all-ones for the rest of the accumulation.
REQ-030 Macro ACC_SATURATE_EN undefined: acc_sum SHALL wrap modulo 2^ACC_W; overflow behaves identically in both builds.

Verification
REQ-031 start with term_count=4; feed 240, 323, 39916800, 479001600 on consecutive cycles -> acc_sum=518918963, acc_terms=4, overflow=0; acc_valid rises one cycle after the 4th product.
REQ-032 term_count=1, single product 144850083840000 with acc_ready held 0 for 5 cycles -> outputs stable through HOLD; IDLE one cycle after acc_ready=1.
REQ-033 term_count=3 with in_valid gaps of 2 cycles between products 2, 3, 4 -> acc_sum=9; in_ready stays 1 throughout.
REQ-034 start again after 2 of 4 products accepted (values 5, 7) -> acc_sum=0, acc_terms=0; then 4 products of 1 -> acc_sum=4.
REQ-035 ACC_W=66, term_count=5, each product 2^64-1 -> overflow=1; with ACC_SATURATE_EN acc_sum=2^66-1; without it acc_sum=2^64-5.
REQ-036 start with term_count=0 -> HOLD next cycle with acc_sum=0; also assert resetn_32b low mid-ACCUM -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mult_result_accum.sv
// Accumulates a programmable number of 64-bit multiplier products into an ACC_W-bit sum with sticky overflow.
// Optional build macro ACC_SATURATE_EN clamps the sum to all-ones on overflow instead of wrapping.
module mult_result_accum #(
   parameter int ACC_W = 80,
   parameter int CNT_W = 8
) (
   input  logic             clk_32b,
   input  logic             resetn_32b,
   input  logic             start,
   input  logic [CNT_W-1:0] term_count,
   input  logic             in_valid,
   input  logic [63:0]      result_64b,
   output logic             in_ready,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic [ACC_W-1:0] acc_sum,
   output logic [CNT_W-1:0] acc_terms,
   output logic             overflow
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] count_lat;
   logic [CNT_W-1:0] terms_next;
   logic [ACC_W:0]   sum_ext;
   logic [ACC_W-1:0] sum_next;
   logic             carry;
   logic             accept;
   logic             restart;
   logic             last_term;

   // start is honoured in IDLE and ACCUM only; a restart discards any product offered that cycle
   assign restart    = start && (state != HOLD);
   assign accept     = (state == ACCUM) && in_valid && !start;
   assign terms_next = acc_terms + CNT_W'(1);
   assign last_term  = accept && (terms_next == count_lat);
   assign sum_ext    = {1'b0, acc_sum} + {{(ACC_W - 63){1'b0}}, result_64b};
   assign carry      = sum_ext[ACC_W];

`ifdef ACC_SATURATE_EN
   // Once overflow is sticky the sum is pinned at all-ones until the next start
   assign sum_next = (carry || overflow) ? '1 : sum_ext[ACC_W-1:0];
`else
   assign sum_next = sum_ext[ACC_W-1:0];
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_32b or negedge resetn_32b) begin
      if (!resetn_32b) state <= IDLE;
      else             state <= state_next;
   end

   // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (term_count == '0) ? HOLD : ACCUM;
         ACCUM: begin
            if (start)          state_next = (term_count == '0) ? HOLD : ACCUM;
            else if (last_term) state_next = HOLD;
         end
         HOLD:    if (acc_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      acc_valid = 1'b0;
      case (state)
         ACCUM:   in_ready  = 1'b1;
         HOLD:    acc_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_32b or negedge resetn_32b) begin
      if (!resetn_32b) begin
         acc_sum   <= '0;
         acc_terms <= '0;
         overflow  <= 1'b0;
         count_lat <= '0;
      end else if (restart) begin
         acc_sum   <= '0;
         acc_terms <= '0;
         overflow  <= 1'b0;
         count_lat <= term_count;
      end else if (accept) begin
         acc_sum   <= sum_next;
         acc_terms <= terms_next;
         overflow  <= overflow | carry;
      end
   end

endmodule

// File: tb/tb_mult_result_accum.sv
// Directed bench for mult_result_accum: stimulus pushes expected final results into a queue,
// a monitor pops and compares each time acc_valid rises.
module tb_mult_result_accum;

   localparam int ACC_W = 66;
   localparam int CNT_W = 8;

   typedef struct {
      logic [ACC_W-1:0] sum;
      logic [CNT_W-1:0] terms;
      logic             ovf;
   } exp_t;

   logic             clk_32b = 1'b0;
   logic             resetn_32b;
   logic             start;
   logic [CNT_W-1:0] term_count;
   logic             in_valid;
   logic [63:0]      result_64b;
   logic             in_ready;
   logic             acc_valid;
   logic             acc_ready;
   logic [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0] acc_terms;
   logic             overflow;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic prev_valid = 1'b0;

   mult_result_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk_32b    (clk_32b),
      .resetn_32b (resetn_32b),
      .start      (start),
      .term_count (term_count),
      .in_valid   (in_valid),
      .result_64b (result_64b),
      .in_ready   (in_ready),
      .acc_valid  (acc_valid),
      .acc_ready  (acc_ready),
      .acc_sum    (acc_sum),
      .acc_terms  (acc_terms),
      .overflow   (overflow)
   );

   always #5 clk_32b = ~clk_32b;

   task automatic check(input string name, input logic [79:0] actual, input logic [79:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Scoreboard monitor: compares the held result on each rising edge of acc_valid
   always @(negedge clk_32b) begin
      if (!resetn_32b) begin
         prev_valid = 1'b0;
      end else begin
         if (acc_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_sum", acc_sum, e.sum);
               check("sb_terms", acc_terms, e.terms);
               check("sb_overflow", overflow, e.ovf);
            end
         end
         prev_valid = acc_valid;
      end
   end

   task automatic tick();
      @(posedge clk_32b);
      #1;
   endtask

   task automatic do_start(input logic [CNT_W-1:0] n);
      start      = 1'b1;
      term_count = n;
      tick();
      start      = 1'b0;
   endtask

   task automatic feed(input logic [63:0] v);
      in_valid   = 1'b1;
      result_64b = v;
      tick();
      in_valid   = 1'b0;
   endtask

   task automatic push(input logic [ACC_W-1:0] s, input logic [CNT_W-1:0] t, input logic o);
      exp_t e;
      e.sum = s; e.terms = t; e.ovf = o;
      exp_q.push_back(e);
   endtask

   task automatic release_hold();
      acc_ready = 1'b1;
      tick();
      check("release_valid_low", acc_valid, 0);
      acc_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn_32b = 1'b0;
      start      = 1'b0;
      term_count = '0;
      in_valid   = 1'b0;
      result_64b = '0;
      acc_ready  = 1'b0;
      #12;
      check("rst_in_ready", in_ready, 0);
      check("rst_acc_valid", acc_valid, 0);
      check("rst_sum", acc_sum, 0);
      check("rst_terms", acc_terms, 0);
      check("rst_overflow", overflow, 0);
      #5 resetn_32b = 1'b1;
      tick();

      // Four factorial-style products back to back
      do_start(4);
      check("accum_in_ready", in_ready, 1);
      push(66'd518918963, 8'd4, 1'b0);
      feed(64'd240);
      feed(64'd323);
      feed(64'd39916800);
      check("third_terms", acc_terms, 3);
      check("third_valid_low", acc_valid, 0);
      feed(64'd479001600);
      check("fourth_valid_high", acc_valid, 1);
      check("fourth_in_ready_low", in_ready, 0);
      release_hold();

      // Single product held while acc_ready stays low; start during HOLD is ignored
      do_start(1);
      push(66'd144850083840000, 8'd1, 1'b0);
      feed(64'd144850083840000);
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         term_count = 8'd3;
         tick();
         check("hold_valid", acc_valid, 1);
         check("hold_sum", acc_sum, 66'd144850083840000);
         check("hold_terms", acc_terms, 1);
      end
      start = 1'b0;
      release_hold();
      check("idle_in_ready", in_ready, 0);

      // Gaps between products
      do_start(3);
      push(66'd9, 8'd3, 1'b0);
      feed(64'd2);
      for (int i = 0; i < 2; i++) begin tick(); check("gap_in_ready", in_ready, 1); end
      feed(64'd3);
      for (int i = 0; i < 2; i++) begin tick(); check("gap_in_ready", in_ready, 1); end
      feed(64'd4);
      release_hold();

      // Restart mid-accumulation; the product offered with start is dropped
      do_start(4);
      feed(64'd5);
      feed(64'd7);
      check("pre_abort_sum", acc_sum, 12);
      start = 1'b1; term_count = 8'd4; in_valid = 1'b1; result_64b = 64'd100;
      tick();
      start = 1'b0; in_valid = 1'b0;
      check("abort_sum", acc_sum, 0);
      check("abort_terms", acc_terms, 0);
      check("abort_in_ready", in_ready, 1);
      push(66'd4, 8'd4, 1'b0);
      for (int i = 0; i < 4; i++) feed(64'd1);
      release_hold();

      // Carry out of ACC_W bits on the fifth all-ones product
      do_start(5);
`ifdef ACC_SATURATE_EN
      push({ACC_W{1'b1}}, 8'd5, 1'b1);
`else
      push(66'h0_FFFF_FFFF_FFFF_FFFB, 8'd5, 1'b1);
`endif
      for (int i = 0; i < 4; i++) feed(64'hFFFF_FFFF_FFFF_FFFF);
      check("pre_carry_overflow", overflow, 0);
      feed(64'hFFFF_FFFF_FFFF_FFFF);
      release_hold();

      // Zero-length accumulation goes straight to HOLD
      do_start(0);
      push(66'd0, 8'd0, 1'b0);
      check("zero_valid", acc_valid, 1);
      check("zero_sum", acc_sum, 0);
      check("zero_overflow", overflow, 0);
      release_hold();

      // Asynchronous reset in the middle of an accumulation
      do_start(4);
      feed(64'd9);
      #2 resetn_32b = 1'b0;
      #1;
      check("async_in_ready", in_ready, 0);
      check("async_valid", acc_valid, 0);
      check("async_sum", acc_sum, 0);
      check("async_terms", acc_terms, 0);
      #3 resetn_32b = 1'b1;
      in_valid = 1'b1; result_64b = 64'd50;
      tick();
      tick();
      in_valid = 1'b0;
      check("post_rst_in_ready", in_ready, 0);
      check("post_rst_terms", acc_terms, 0);
      do_start(2);
      push(66'd7, 8'd2, 1'b0);
      feed(64'd3);
      feed(64'd4);
      release_hold();

      tick();
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
